// File: rtl/if_id_redirect_pkg.sv
// Shared definitions for the IF/ID redirect slice: PC/instruction widths, branch opcode, BQ entry layout.
// BQ entry packs {pc, take}: take occupies bit 0 and pc sits above it.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

package if_id_redirect_pkg;
    localparam int         PC_SIZE_P    = `PC_SIZE;
    localparam int         INSTR_SIZE_P = `INSTR_SIZE;
    localparam int         BQ_TAKE_BIT  = 0;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;

    function automatic logic is_branch(input logic [6:0] opc);
        return (opc == OPC_BRANCH);
    endfunction
endpackage

// File: rtl/if_id_redirect_br_queue.sv
// Circular FIFO holding unresolved predicted branches; clear wins over push and pop.
module br_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 33,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] rd_r;
    logic [AW-1:0] wr_r;
    logic [CW-1:0] cnt_r;

    assign dout  = mem_r[rd_r];
    assign full  = (cnt_r == CW'(DEPTH));
    assign empty = (cnt_r == {CW{1'b0}});

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_r  <= {AW{1'b0}};
            wr_r  <= {AW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            rd_r  <= {AW{1'b0}};
            wr_r  <= {AW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else begin
            if (push) wr_r <= wr_r + AW'(1);
            if (pop)  rd_r <= rd_r + AW'(1);
            case ({push, pop})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
        end else if (push && !clear) begin
            mem_r[wr_r] <= din;
        end
    end
endmodule

// File: rtl/if_id_redirect.sv
// IF/ID pipeline register plus in-order branch queue with mispredict redirect to fetch.
// Optional BR_STAT_EN adds saturating resolve/mispredict counters (stat_br, stat_mis).
module if_id_redirect
    import if_id_redirect_pkg::*;
#(
    parameter int PC_W     = PC_SIZE_P,
    parameter int INSTR_W  = INSTR_SIZE_P,
    parameter int BQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               pc_rst_n,
    input  logic               if_valid,
    input  logic [PC_W-1:0]    if_pc,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic               if_take,
    output logic               if_ready,
    output logic               id_valid,
    output logic [PC_W-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic               id_take,
    input  logic               id_ready,
    input  logic               id_jalr,
    input  logic               ex_br_valid,
    input  logic               ex_br_taken,
    input  logic [PC_W-1:0]    ex_br_imm,
    output logic               predict_fail,
    output logic [PC_W-1:0]    bxx_fail_pc,
    output logic [PC_W-1:0]    bxx_fail_imm,
    output logic               bq_err
`ifdef BR_STAT_EN
    ,
    output logic [31:0]        stat_br,
    output logic [31:0]        stat_mis
`endif
);
    logic          bq_full_s;
    logic          bq_empty_s;
    logic [PC_W:0] bq_head_s;
    logic          accept_s;
    logic          load_s;
    logic          push_s;
    logic          pop_s;
    logic          mis_s;

    // Full check ignores a same-cycle pop so if_ready never depends on EX.
    assign if_ready = (!id_valid || id_ready) && !bq_full_s;

    // Handshake decode: a word arriving while fetch is being redirected is discarded.
    always_comb begin
        accept_s = if_valid && if_ready;
        load_s   = accept_s && !id_jalr && !predict_fail;
        pop_s    = ex_br_valid && !bq_empty_s;
        mis_s    = pop_s && (ex_br_taken ^ bq_head_s[BQ_TAKE_BIT]);
        push_s   = load_s && is_branch(if_instr[6:0]) && !mis_s;
    end

    br_queue #(
        .DEPTH (BQ_DEPTH),
        .W     (PC_W + 1)
    ) u_bq (
        .clk   (clk),
        .rst_n (pc_rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .clear (mis_s),
        .din   ({if_pc, if_take}),
        .dout  (bq_head_s),
        .full  (bq_full_s),
        .empty (bq_empty_s)
    );

    // IF/ID register: flush beats load, load beats hand-off.
    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            id_valid <= 1'b0;
            id_pc    <= {PC_W{1'b0}};
            id_instr <= {INSTR_W{1'b0}};
            id_take  <= 1'b0;
        end else if (mis_s) begin
            id_valid <= 1'b0;
        end else if (load_s) begin
            id_valid <= 1'b1;
            id_pc    <= if_pc;
            id_instr <= if_instr;
            id_take  <= if_take;
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end

    // Redirect outputs: one-cycle pulse, fail PC/imm held until the next mispredict.
    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            predict_fail <= 1'b0;
            bxx_fail_pc  <= {PC_W{1'b0}};
            bxx_fail_imm <= {PC_W{1'b0}};
            bq_err       <= 1'b0;
        end else begin
            predict_fail <= mis_s;
            bq_err       <= bq_err || (ex_br_valid && bq_empty_s);
            if (mis_s) begin
                bxx_fail_pc  <= bq_head_s[PC_W:1];
                bxx_fail_imm <= ex_br_imm;
            end
        end
    end

`ifdef BR_STAT_EN
    // Saturating branch statistics.
    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            stat_br  <= 32'd0;
            stat_mis <= 32'd0;
        end else begin
            if (pop_s && (stat_br != 32'hFFFF_FFFF))  stat_br  <= stat_br + 32'd1;
            if (mis_s && (stat_mis != 32'hFFFF_FFFF)) stat_mis <= stat_mis + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_id_redirect.sv
// Scoreboard bench for if_id_redirect: directed stimulus pushes expectations, a monitor pops and compares.
module tb_if_id_redirect;
    import if_id_redirect_pkg::*;

    localparam int PC_W    = PC_SIZE_P;
    localparam int INSTR_W = INSTR_SIZE_P;
    localparam logic [INSTR_W-1:0] BR_W  = 32'h0000_0063;
    localparam logic [INSTR_W-1:0] ALU_W = 32'h00A0_0013;

    logic               clk = 1'b0;
    logic               pc_rst_n = 1'b0;
    logic               if_valid = 1'b0;
    logic [PC_W-1:0]    if_pc = '0;
    logic [INSTR_W-1:0] if_instr = '0;
    logic               if_take = 1'b0;
    logic               if_ready;
    logic               id_valid;
    logic [PC_W-1:0]    id_pc;
    logic [INSTR_W-1:0] id_instr;
    logic               id_take;
    logic               id_ready = 1'b0;
    logic               id_jalr = 1'b0;
    logic               ex_br_valid = 1'b0;
    logic               ex_br_taken = 1'b0;
    logic [PC_W-1:0]    ex_br_imm = '0;
    logic               predict_fail;
    logic [PC_W-1:0]    bxx_fail_pc;
    logic [PC_W-1:0]    bxx_fail_imm;
    logic               bq_err;
`ifdef BR_STAT_EN
    logic [31:0]        stat_br;
    logic [31:0]        stat_mis;
`endif

    if_id_redirect dut (
        .clk          (clk),
        .pc_rst_n     (pc_rst_n),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_take      (if_take),
        .if_ready     (if_ready),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_take      (id_take),
        .id_ready     (id_ready),
        .id_jalr      (id_jalr),
        .ex_br_valid  (ex_br_valid),
        .ex_br_taken  (ex_br_taken),
        .ex_br_imm    (ex_br_imm),
        .predict_fail (predict_fail),
        .bxx_fail_pc  (bxx_fail_pc),
        .bxx_fail_imm (bxx_fail_imm),
        .bq_err       (bq_err)
`ifdef BR_STAT_EN
        ,
        .stat_br      (stat_br),
        .stat_mis     (stat_mis)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr; logic take; } id_exp_t;
    typedef struct { logic [PC_W-1:0] pc; logic [PC_W-1:0] imm; } fail_exp_t;
    id_exp_t   expq[$];
    fail_exp_t failq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event occurred with no matching expectation", name);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ID hand-off and every redirect pulse must match the next expectation.
    always @(negedge clk) begin : monitor
        id_exp_t   e;
        fail_exp_t f;
        if (pc_rst_n) begin
            if (id_valid && id_ready) begin
                if (expq.size() == 0) fail_now("id_unexpected");
                else begin
                    e = expq.pop_front();
                    check("id_pc", id_pc, e.pc);
                    check("id_instr", id_instr, e.instr);
                    check("id_take", id_take, e.take);
                end
            end
            if (predict_fail) begin
                if (failq.size() == 0) fail_now("predict_fail_unexpected");
                else begin
                    f = failq.pop_front();
                    check("bxx_fail_pc", bxx_fail_pc, f.pc);
                    check("bxx_fail_imm", bxx_fail_imm, f.imm);
                end
            end
        end
    end

    task automatic send(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] instr,
                        input logic take, input bit expect_load);
        int  n = 0;
        bit  done = 1'b0;
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr;
        if_take  = take;
        while (!done) begin
            @(negedge clk);
            if (if_ready) begin
                done = 1'b1;
                if (expect_load) expq.push_back('{pc, instr, take});
            end else if (++n > 50) begin
                fail_now("send_timeout");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if_valid = 1'b0;
        if (expect_load) begin
            check("load_valid", id_valid, 64'd1);
            check("load_pc", id_pc, pc);
        end
    endtask

    task automatic br_resolve(input logic [PC_W-1:0] pc, input logic take,
                              input logic taken, input logic [PC_W-1:0] imm);
        send(pc, BR_W, take, 1'b1);
        ex_br_valid = 1'b1;
        ex_br_taken = taken;
        ex_br_imm   = imm;
        if (take != taken) failq.push_back('{pc, imm});
        cyc();
        ex_br_valid = 1'b0;
        cyc();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_id_valid"}, id_valid, 64'd0);
        check({tag, "_id_pc"}, id_pc, 64'd0);
        check({tag, "_id_instr"}, id_instr, 64'd0);
        check({tag, "_predict_fail"}, predict_fail, 64'd0);
        check({tag, "_bxx_fail_pc"}, bxx_fail_pc, 64'd0);
        check({tag, "_bxx_fail_imm"}, bxx_fail_imm, 64'd0);
        check({tag, "_bq_err"}, bq_err, 64'd0);
        check({tag, "_bq_cnt"}, dut.u_bq.cnt_r, 64'd0);
`ifdef BR_STAT_EN
        check({tag, "_stat_br"}, stat_br, 64'd0);
        check({tag, "_stat_mis"}, stat_mis, 64'd0);
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        pc_rst_n = 1'b1;
        cyc();

        // 1: stream of non-branch words, one-cycle latency, BQ untouched
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(PC_W'(32'h1000 + 4 * i), ALU_W + INSTR_W'(i), 1'b0, 1'b1);
        check("t1_bq_cnt", dut.u_bq.cnt_r, 64'd0);
        cyc();

        // 2: decode stall holds ID and blocks fetch, then resumes in order
        id_ready = 1'b0;
        send(PC_W'(32'h2000), ALU_W + INSTR_W'(16), 1'b1, 1'b1);
        if_valid = 1'b1;
        if_pc    = PC_W'(32'h2004);
        if_instr = ALU_W + INSTR_W'(17);
        if_take  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_if_ready", if_ready, 64'd0);
            check("t2_id_pc_hold", id_pc, 64'h2000);
            check("t2_id_instr_hold", id_instr, ALU_W + INSTR_W'(16));
            @(posedge clk);
            #1;
        end
        id_ready = 1'b1;
        send(PC_W'(32'h2004), ALU_W + INSTR_W'(17), 1'b0, 1'b1);
        cyc();

        // 3: fill BQ, fifth branch waits for a pop plus one cycle
        for (int i = 0; i < 4; i++) send(PC_W'(32'h200 + 4 * i), BR_W, 1'b0, 1'b1);
        check("t3_bq_full", dut.u_bq.cnt_r, 64'd4);
        if_valid = 1'b1;
        if_pc    = PC_W'(32'h210);
        if_instr = BR_W;
        if_take  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t3_if_ready_full", if_ready, 64'd0);
            @(posedge clk);
            #1;
        end
        ex_br_valid = 1'b1;
        ex_br_taken = 1'b0;
        @(negedge clk);
        check("t3_if_ready_pop_cycle", if_ready, 64'd0);
        @(posedge clk);
        #1;
        ex_br_valid = 1'b0;
        @(negedge clk);
        check("t3_if_ready_after_pop", if_ready, 64'd1);
        expq.push_back('{PC_W'(32'h210), BR_W, 1'b0});
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        check("t3_bq_refill", dut.u_bq.cnt_r, 64'd4);
        ex_br_valid = 1'b1;
        repeat (4) cyc();
        ex_br_valid = 1'b0;
        check("t3_bq_drained", dut.u_bq.cnt_r, 64'd0);

        // 4: mispredict redirect; wrong-path words during and after it are dropped
        send(PC_W'(32'h100), BR_W, 1'b1, 1'b1);
        ex_br_valid = 1'b1;
        ex_br_taken = 1'b0;
        ex_br_imm   = PC_W'(32'h20);
        failq.push_back('{PC_W'(32'h100), PC_W'(32'h20)});
        if_valid = 1'b1;
        if_pc    = PC_W'(32'h300);
        if_instr = BR_W;
        cyc();
        ex_br_valid = 1'b0;
        check("t4_predict_fail", predict_fail, 64'd1);
        check("t4_fail_pc", bxx_fail_pc, 64'h100);
        check("t4_fail_imm", bxx_fail_imm, 64'h20);
        check("t4_id_flushed", id_valid, 64'd0);
        check("t4_bq_cleared", dut.u_bq.cnt_r, 64'd0);
        cyc();
        if_valid = 1'b0;
        check("t4_pulse_end", predict_fail, 64'd0);
        check("t4_drop_during_pulse", id_valid, 64'd0);
        check("t4_no_push", dut.u_bq.cnt_r, 64'd0);
        check("t4_fail_pc_hold", bxx_fail_pc, 64'h100);

        // 5: jalr drops the incoming word, resolve on empty BQ sets sticky error
        id_ready = 1'b0;
        send(PC_W'(32'h400), ALU_W, 1'b0, 1'b1);
        id_ready = 1'b1;
        id_jalr  = 1'b1;
        if_valid = 1'b1;
        if_pc    = PC_W'(32'h404);
        if_instr = BR_W;
        cyc();
        id_jalr  = 1'b0;
        if_valid = 1'b0;
        check("t5_jalr_drop", id_valid, 64'd0);
        check("t5_jalr_no_push", dut.u_bq.cnt_r, 64'd0);
        ex_br_valid = 1'b1;
        ex_br_taken = 1'b1;
        cyc();
        ex_br_valid = 1'b0;
        check("t5_bq_err", bq_err, 64'd1);
        check("t5_no_fail", predict_fail, 64'd0);
        cyc();
        check("t5_bq_err_sticky", bq_err, 64'd1);

        // 6: async reset mid-operation with a mispredict pending, no pulse afterwards
        id_ready = 1'b0;
        send(PC_W'(32'h500), BR_W, 1'b0, 1'b1);
        ex_br_valid = 1'b1;
        ex_br_taken = 1'b1;
        ex_br_imm   = PC_W'(32'h40);
        #2;
        pc_rst_n = 1'b0;
        expq.delete();
        #1;
        check_reset_state("midreset");
        cyc();
        ex_br_valid = 1'b0;
        pc_rst_n    = 1'b1;
        cyc();
        check("midreset_no_pulse", predict_fail, 64'd0);
        id_ready = 1'b1;

`ifdef BR_STAT_EN
        br_resolve(PC_W'(32'h600), 1'b0, 1'b0, PC_W'(32'h8));
        br_resolve(PC_W'(32'h604), 1'b1, 1'b0, PC_W'(32'h10));
        br_resolve(PC_W'(32'h608), 1'b1, 1'b1, PC_W'(32'h18));
        br_resolve(PC_W'(32'h60C), 1'b0, 1'b1, PC_W'(32'h24));
        br_resolve(PC_W'(32'h610), 1'b0, 1'b0, PC_W'(32'h30));
        check("stat_br_5", stat_br, 64'd5);
        check("stat_mis_2", stat_mis, 64'd2);
        check("stat_fail_pc_last", bxx_fail_pc, 64'h60C);
        send(PC_W'(32'h700), BR_W, 1'b0, 1'b1);
        #2;
        pc_rst_n = 1'b0;
        expq.delete();
        #1;
        check_reset_state("stat_reset");
        cyc();
        pc_rst_n = 1'b1;
        cyc();
`else
        br_resolve(PC_W'(32'h600), 1'b0, 1'b1, PC_W'(32'h44));
        check("wrap_fail_pc", bxx_fail_pc, 64'h600);
        check("wrap_fail_imm", bxx_fail_imm, 64'h44);
`endif
        repeat (2) cyc();
        check("expq_drained", 64'(expq.size()), 64'd0);
        check("failq_drained", 64'(failq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
